// File: rtl/rng_bit_collector.sv
// rng_bit_collector
//   Transmitter end of the collector->CRNGT word interface in the TRNG datapath.
//   The raw ring-oscillator bit is synchronised, sampled once every
//   max(sample_cnt,1) enabled clocks, packed MSB-first into 16-bit words and
//   queued in a small FIFO whose head is presented to the CRNGT stage.
//
// Ports
//   rng_clk               in   TRNG clock
//   rst_n                 in   asynchronous active-low reset (clears everything)
//   rnd_src_en            in   random source enable; 0 freezes sampling
//   rnd_bit               in   raw ROSC output, asynchronous to rng_clk
//   sample_cnt            in   clocks between samples (0 treated as 1), read live
//   rst_trng_logic        in   synchronous soft clear (not the synchroniser)
//   crngt_collector_rd    in   CRNGT pops the FIFO head this cycle
//   collector_crngt_data  out  FIFO head word, 0 when empty
//   collector_valid       out  FIFO not empty
//   collector_overflow    out  sticky: a completed word was dropped
module rng_bit_collector #(
  parameter int unsigned SAMPLE_W   = 16,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic                rng_clk,
  input  logic                rst_n,
  input  logic                rnd_src_en,
  input  logic                rnd_bit,
  input  logic [SAMPLE_W-1:0] sample_cnt,
  input  logic                rst_trng_logic,
  input  logic                crngt_collector_rd,
  output logic [15:0]         collector_crngt_data,
  output logic                collector_valid,
  output logic                collector_overflow
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  // Synchroniser
  logic r_sync1;
  logic r_sync2;

  // Decimation counter
  logic [SAMPLE_W-1:0] r_cnt;
  logic [SAMPLE_W-1:0] w_limit_m1;
  logic                w_tick;
  logic                w_cnt_over;

  // Packing: only the 15 most recent samples need storing; the 16th comes
  // straight from the synchroniser when the word is pushed.
  logic [14:0] r_shift;
  logic [3:0]  r_bit_cnt;
  logic [15:0] w_word;
  logic        w_push;

  // FIFO
  logic [15:0]    r_mem [FIFO_DEPTH];
  logic [PTR_W:0] r_wr_ptr;
  logic [PTR_W:0] r_rd_ptr;
  logic [PTR_W:0] w_level;
  logic           w_empty;
  logic           w_full;
  logic           w_pop;
  logic           w_accept;
  logic           r_overflow;

  always_ff @(posedge rng_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
    end else begin
      r_sync1 <= rnd_bit;
      r_sync2 <= r_sync1;
    end
  end

  always_comb begin
    w_limit_m1 = (sample_cnt == '0) ? '0 : sample_cnt - SAMPLE_W'(1);
    w_tick     = rnd_src_en & (r_cnt == w_limit_m1);
    // A live reduction of sample_cnt can leave the counter beyond the new
    // limit; it then wraps to 0 on the next enabled cycle without a tick.
    w_cnt_over = (r_cnt > w_limit_m1);
  end

  always_comb begin
    w_word   = {r_shift, r_sync2};
    w_push   = w_tick & (r_bit_cnt == 4'd15);
    w_level  = r_wr_ptr - r_rd_ptr;
    w_empty  = (r_wr_ptr == r_rd_ptr);
    w_full   = (w_level == (PTR_W + 1)'(FIFO_DEPTH));
    w_pop    = crngt_collector_rd & ~w_empty;
    // When full, a simultaneous pop frees the slot the push lands in.
    w_accept = w_push & (~w_full | w_pop);
  end

  always_ff @(posedge rng_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (rst_trng_logic) begin
      r_cnt     <= '0;
      r_shift   <= '0;
      r_bit_cnt <= '0;
    end else if (rnd_src_en) begin
      if (w_tick || w_cnt_over) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + SAMPLE_W'(1);
      end
      if (w_tick) begin
        r_shift   <= w_word[14:0];
        r_bit_cnt <= r_bit_cnt + 4'd1;
      end
    end
  end

  always_ff @(posedge rng_clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else if (rst_trng_logic) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + (PTR_W + 1)'(1);
      end
      if (w_accept) begin
        r_wr_ptr <= r_wr_ptr + (PTR_W + 1)'(1);
      end
      if (w_push && !w_accept) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Storage needs no reset: it is only observed through a non-empty head.
  always_ff @(posedge rng_clk) begin
    if (!rst_trng_logic && w_accept) begin
      r_mem[r_wr_ptr[PTR_W-1:0]] <= w_word;
    end
  end

  always_comb begin
    collector_valid      = ~w_empty;
    collector_crngt_data = w_empty ? '0 : r_mem[r_rd_ptr[PTR_W-1:0]];
    collector_overflow   = r_overflow;
  end

endmodule

// File: tb/tb_rng_bit_collector.sv
module tb_rng_bit_collector;

  localparam int SW    = 16;
  localparam int DEPTH = 2;

  logic          rng_clk = 1'b0;
  logic          rst_n;
  logic          rnd_src_en;
  logic          rnd_bit;
  logic [SW-1:0] sample_cnt;
  logic          rst_trng_logic;
  logic          crngt_collector_rd;
  logic [15:0]   collector_crngt_data;
  logic          collector_valid;
  logic          collector_overflow;

  always #5 rng_clk = ~rng_clk;

  rng_bit_collector #(.SAMPLE_W(SW), .FIFO_DEPTH(DEPTH)) dut (
    .rng_clk             (rng_clk),
    .rst_n               (rst_n),
    .rnd_src_en          (rnd_src_en),
    .rnd_bit             (rnd_bit),
    .sample_cnt          (sample_cnt),
    .rst_trng_logic      (rst_trng_logic),
    .crngt_collector_rd  (crngt_collector_rd),
    .collector_crngt_data(collector_crngt_data),
    .collector_valid     (collector_valid),
    .collector_overflow  (collector_overflow)
  );

  int tests = 0;
  int fails = 0;

  // Reference model: synchroniser pipeline, decimation position, collected
  // bits as a queue, FIFO as a queue of words.
  bit          m_s1, m_s2;
  int          m_cnt;
  bit          m_bits[$];
  logic [15:0] m_q[$];
  bit          m_ovf;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_s1 = 0; m_s2 = 0; m_cnt = 0; m_ovf = 0;
    m_bits.delete();
    m_q.delete();
  endtask

  task automatic model_edge(input bit clr, input bit en, input bit rd, input bit b,
                            input logic [15:0] sc);
    int          lim;
    bit          tick, pop, push;
    logic [15:0] w;
    lim = (sc == 0) ? 1 : int'(sc);
    tick = 0; push = 0; w = '0;
    if (clr) begin
      m_cnt = 0;
      m_bits.delete();
      m_q.delete();
      m_ovf = 0;
    end else begin
      if (en) begin
        if (m_cnt == lim - 1) begin tick = 1; m_cnt = 0; end
        else if (m_cnt >= lim) m_cnt = 0;
        else m_cnt++;
      end
      pop = rd && (m_q.size() > 0);
      if (tick) begin
        m_bits.push_back(m_s2);
        if (m_bits.size() == 16) begin
          foreach (m_bits[i]) w[15-i] = m_bits[i];
          m_bits.delete();
          push = 1;
        end
      end
      if (pop) void'(m_q.pop_front());
      if (push) begin
        if (m_q.size() < DEPTH) m_q.push_back(w);
        else m_ovf = 1;
      end
    end
    m_s2 = m_s1;
    m_s1 = b;
  endtask

  task automatic check_model();
    logic [15:0] exp_data;
    bit          exp_valid;
    exp_valid = (m_q.size() != 0);
    exp_data  = exp_valid ? m_q[0] : 16'h0;
    tests++;
    if (collector_valid !== exp_valid || collector_crngt_data !== exp_data ||
        collector_overflow !== m_ovf) begin
      fails++;
      $display("FAIL model: got v=%0b d=%h o=%0b, expected v=%0b d=%h o=%0b at %0t",
               collector_valid, collector_crngt_data, collector_overflow,
               exp_valid, exp_data, m_ovf, $time);
    end
  endtask

  // Drive one cycle from a negedge, let the posedge happen, sample at next negedge.
  task automatic step(input bit clr, input bit en, input bit rd, input bit b,
                      input logic [15:0] sc);
    rst_trng_logic     = clr;
    rnd_src_en         = en;
    crngt_collector_rd = rd;
    rnd_bit            = b;
    sample_cnt         = sc;
    model_edge(clr, en, rd, b, sc);
    @(negedge rng_clk);
    check_model();
  endtask

  typedef struct {
    logic [15:0] sc;
    logic [15:0] pattern;
    logic [15:0] exp_data;
    int          exp_cycles;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{16'd1, 16'hFFFF, 16'hFFFF, 16};
    vecs[1] = '{16'd3, 16'hAAAA, 16'hAAAA, 48};
    vecs[2] = '{16'd0, 16'h1234, 16'h1234, 16};
    vecs[3] = '{16'd2, 16'h8001, 16'h8001, 32};
    vecs[4] = '{16'd5, 16'hC3A5, 16'hC3A5, 80};

    rst_n = 0; rnd_src_en = 0; rnd_bit = 0; sample_cnt = 16'd1;
    rst_trng_logic = 0; crngt_collector_rd = 0;
    model_reset();
    repeat (3) @(negedge rng_clk);
    rst_n = 1;
    check("reset_valid", collector_valid, 0);
    check("reset_data", collector_crngt_data, 0);
    check("reset_ovf", collector_overflow, 0);
    step(0, 0, 1, 0, 16'd1);  // rd while empty is ignored

    // Table: ticks land at steps k*L; rnd_bit driven at step k*L-2 reaches the sampler.
    foreach (vecs[v]) begin
      int L;
      L = (vecs[v].sc == 0) ? 1 : int'(vecs[v].sc);
      step(1, 0, 0, 0, vecs[v].sc);
      for (int n = -1; n <= vecs[v].exp_cycles; n++) begin
        bit b;
        int k;
        b = 1'($urandom % 2);
        if ((n + 2) % L == 0) begin
          k = (n + 2) / L;
          if (k >= 1 && k <= 16) b = vecs[v].pattern[16-k];
        end
        step(0, n >= 1, 0, b, vecs[v].sc);
        if (n == vecs[v].exp_cycles - 1)
          check($sformatf("vec%0d_early_valid", v), collector_valid, 0);
        if (n == vecs[v].exp_cycles) begin
          check($sformatf("vec%0d_valid", v), collector_valid, 1);
          check($sformatf("vec%0d_data", v), collector_crngt_data, vecs[v].exp_data);
        end
      end
    end

    // Overflow with no reads: level saturates at 2, head stays word 1.
    step(1, 0, 0, 1, 16'd1);
    step(0, 0, 0, 1, 16'd1);
    step(0, 0, 0, 1, 16'd1);
    for (int n = 1; n <= 48; n++) begin
      step(0, 1, 0, 1, 16'd1);
      if (n == 16) check("ovf_first_word", collector_crngt_data, 16'hFFFF);
      if (n == 47) check("ovf_not_yet", collector_overflow, 0);
    end
    check("ovf_set", collector_overflow, 1);
    check("ovf_head", collector_crngt_data, 16'hFFFF);
    step(0, 0, 1, 1, 16'd1);
    check("ovf_level2_a", collector_valid, 1);
    step(0, 0, 1, 1, 16'd1);
    check("ovf_level2_b", collector_valid, 0);
    check("ovf_sticky", collector_overflow, 1);

    // Full FIFO, read on the cycle word 3 completes: words FFFF, 0000, FFFF.
    step(1, 0, 0, 1, 16'd1);
    for (int n = -1; n <= 48; n++) begin
      int t;
      t = n + 2;
      step(0, n >= 1, n == 48, ((t - 1) / 16) != 1, 16'd1);
    end
    check("full_rd_ovf", collector_overflow, 0);
    check("full_rd_head", collector_crngt_data, 16'h0000);
    step(0, 0, 1, 0, 16'd1);
    check("full_rd_word3", collector_crngt_data, 16'hFFFF);
    step(0, 0, 1, 0, 16'd1);
    check("full_rd_level", collector_valid, 0);

    // Enable gap after 8 bits: pre-gap ones, post-gap zeros.
    begin
      bit seen_valid;
      seen_valid = 0;
      step(1, 0, 0, 1, 16'd1);
      step(0, 0, 0, 1, 16'd1);
      step(0, 0, 0, 1, 16'd1);
      for (int n = 1; n <= 8; n++) step(0, 1, 0, n <= 6, 16'd1);
      for (int n = 9; n <= 28; n++) begin
        step(0, 0, 0, 0, 16'd1);
        if (collector_valid) seen_valid = 1;
      end
      check("gap_no_valid", seen_valid, 0);
      for (int n = 29; n <= 36; n++) begin
        step(0, 1, 0, 0, 16'd1);
        if (n == 35) check("gap_early_valid", collector_valid, 0);
      end
      check("gap_valid", collector_valid, 1);
      check("gap_data", collector_crngt_data, 16'hFF00);
    end

    // Soft clear with 1 word queued, overflow set and 5 bits packed.
    step(1, 0, 0, 1, 16'd1);
    step(0, 0, 0, 1, 16'd1);
    step(0, 0, 0, 1, 16'd1);
    for (int n = 1; n <= 48; n++) step(0, 1, 0, 1, 16'd1);
    step(0, 0, 1, 1, 16'd1);
    for (int n = 1; n <= 5; n++) step(0, 1, 0, 1, 16'd1);
    check("pre_clr_valid", collector_valid, 1);
    step(1, 1, 1, 1, 16'd1);
    check("clr_valid", collector_valid, 0);
    check("clr_data", collector_crngt_data, 0);
    check("clr_ovf", collector_overflow, 0);
    for (int n = 1; n <= 16; n++) begin
      step(0, 1, 0, 1, 16'd1);
      if (n == 15) check("clr_full_word_early", collector_valid, 0);
    end
    check("clr_full_word", collector_valid, 1);

    // Randomised run; sample_cnt occasionally changes mid-count.
    begin
      logic [15:0] sc;
      sc = 16'd2;
      for (int n = 0; n < 3000; n++) begin
        bit rd;
        if ($urandom % 50 == 0) sc = 16'($urandom % 5);
        rd = (n < 1500) ? ($urandom % 4 == 0) : ($urandom % 64 == 0);
        step($urandom % 300 == 0, $urandom % 8 != 0, rd, 1'($urandom % 2), sc);
      end
    end

    // Asynchronous reset mid-cycle, mid-word.
    #2;
    rst_n = 0;
    #1;
    check("async_rst_valid", collector_valid, 0);
    check("async_rst_data", collector_crngt_data, 0);
    check("async_rst_ovf", collector_overflow, 0);
    model_reset();
    @(negedge rng_clk);
    rst_n = 1;
    for (int n = 0; n < 40; n++) step(0, 1, 0, 1'($urandom % 2), 16'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
